collector_flit_arbiter: RTL and testbench



---
 rtl/noc_flit_pkg.sv | 52 +++++
 rtl/rr_priority_pick.sv | 36 +++
 rtl/collector_flit_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_collector_flit_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: flit width, field offsets and the arbiter FSM
// state type. Collector-side code imports this too, so both ends agree on
// the flit layout.
package noc_flit_pkg;

  // Fixed-width fields of every flit.
  localparam int BYTE_IDX_W = 4;
  localparam int DATA_W     = 8;

  // byte_index value that marks the last (remainder) flit of a packet.
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = 4'd8;

  // Arbiter FSM: free round-robin arbitration, or holding one source.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } fsm_state_t;

  // Flit layout, MSB to LSB:
  //   valid_bit | node_dest | data_byte | packet_id | node_start | byte_index
  function automatic int flit_width(input int node_w, input int pid_w);
    return 1 + 2 * node_w + pid_w + DATA_W + BYTE_IDX_W;
  endfunction

  function automatic int off_byte_index();
    return 0;
  endfunction

  function automatic int off_node_start();
    return BYTE_IDX_W;
  endfunction

  function automatic int off_packet_id(input int node_w);
    return BYTE_IDX_W + node_w;
  endfunction

  function automatic int off_data_byte(input int node_w, input int pid_w);
    return BYTE_IDX_W + node_w + pid_w;
  endfunction

  function automatic int off_node_dest(input int node_w, input int pid_w);
    return off_data_byte(node_w, pid_w) + DATA_W;
  endfunction

  function automatic int off_valid_bit(input int node_w, input int pid_w);
    return off_node_dest(node_w, pid_w) + node_w;
  endfunction

  // Flit width for the default configuration (8 nodes, 5-bit packet id): 24.
  localparam int FLIT_W = flit_width(3, 5);

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: one-hot grant to the first requester found at or
// after ptr, wrapping around. No requester gives an all-zero grant.
module rr_priority_pick #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);

  // One extra bit so ptr + k can exceed N before the wrap is applied; this
  // keeps the pick correct for non-power-of-two N.
  localparam int SW = W + 1;

  logic [SW-1:0] pos;
  logic          found;

  // Scan N positions starting at ptr and keep only the first hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N)) begin
        pos = pos - SW'(N);
      end
      if (!found && req[pos[W-1:0]]) begin
        grant[pos[W-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collector_flit_arbiter.sv
// Flit arbiter in front of the packet collector. Picks among REQ_COUNT flit
// sources round-robin, then holds the winner (LOCK) until its packet ends,
// its key changes or it goes quiet for LOCK_TIMEOUT cycles. The output is a
// single register stage; flits with valid_bit = 0 are swallowed.
module collector_flit_arbiter
  import noc_flit_pkg::*;
#(
  parameter  int NODE_COUNT      = 8,
  parameter  int PACKET_ID_WIDTH = 5,
  parameter  int REQ_COUNT       = 4,
  parameter  int LOCK_TIMEOUT    = 16,
  localparam int NODE_W          = $clog2(NODE_COUNT),
  localparam int REQ_W           = $clog2(REQ_COUNT),
  localparam int FLIT_BITS       = flit_width(NODE_W, PACKET_ID_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ce,
  input  logic [REQ_COUNT-1:0]                req_valid,
  input  logic [REQ_COUNT-1:0][FLIT_BITS-1:0] req_flit,
  output logic [REQ_COUNT-1:0]                req_ready,
  output logic                                out_valid,
  output logic [FLIT_BITS-1:0]                out_flit,
  input  logic                                out_ready,
  output logic                                lock_active,
  output logic [REQ_W-1:0]                    lock_owner
);

  localparam int KEY_W      = NODE_W + PACKET_ID_WIDTH;
  localparam int TO_W       = $clog2(LOCK_TIMEOUT + 1);
  localparam int OFF_BIDX   = off_byte_index();
  localparam int OFF_START  = off_node_start();
  localparam int OFF_PID    = off_packet_id(NODE_W);
  localparam int OFF_VALID  = off_valid_bit(NODE_W, PACKET_ID_WIDTH);

  // Source index after idx, wrapping at REQ_COUNT.
  function automatic logic [REQ_W-1:0] next_src(input logic [REQ_W-1:0] idx);
    if (idx == REQ_W'(REQ_COUNT - 1)) begin
      return '0;
    end else begin
      return idx + 1'b1;
    end
  endfunction

  fsm_state_t           state_reg, state_next;
  logic [REQ_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [REQ_W-1:0]     lock_owner_reg, lock_owner_next;
  logic [KEY_W-1:0]     key_reg, key_next;
  logic [TO_W-1:0]      timeout_reg, timeout_next;
  logic                 out_valid_reg;
  logic [FLIT_BITS-1:0] out_flit_reg;

  logic [REQ_COUNT-1:0] pick_grant;
  logic [REQ_COUNT-1:0] grant;
  logic                 out_free;
  logic                 xfer;
  logic [REQ_W-1:0]     xfer_idx;
  logic [FLIT_BITS-1:0] sel_flit;
  logic                 sel_valid_bit;
  logic                 sel_last;
  logic [KEY_W-1:0]     sel_key;
  logic                 owner_valid;
  logic                 timeout_hit;

  rr_priority_pick #(
    .N (REQ_COUNT)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant)
  );

  // The output register can take a new flit if it is empty or draining now.
  assign out_free = !out_valid_reg || out_ready;

  // In LOCK only the owner is granted; otherwise the round-robin pick rules.
  generate
    for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_grant
      assign grant[gi]     = (state_reg == ST_LOCK) ? (lock_owner_reg == REQ_W'(gi))
                                                    : pick_grant[gi];
      assign req_ready[gi] = ce && grant[gi] && out_free;
    end
  endgenerate

  assign xfer = |(req_valid & req_ready);

  // Encode the one-hot grant into the index of the selected source.
  always_comb begin
    xfer_idx = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      if (grant[k]) begin
        xfer_idx = REQ_W'(k);
      end
    end
  end

  assign sel_flit      = req_flit[xfer_idx];
  assign sel_valid_bit = sel_flit[OFF_VALID];
  assign sel_last      = (sel_flit[OFF_BIDX +: BYTE_IDX_W] == LAST_BYTE_IDX);
  assign sel_key       = {sel_flit[OFF_START +: NODE_W], sel_flit[OFF_PID +: PACKET_ID_WIDTH]};
  assign owner_valid   = req_valid[lock_owner_reg];
  assign timeout_hit   = (timeout_reg == TO_W'(LOCK_TIMEOUT - 1));

  // Next-state logic: lock entry/exit, round-robin pointer and idle timeout.
  // Discarded flits (valid_bit = 0) never touch state, key or pointer.
  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    lock_owner_next = lock_owner_reg;
    key_next        = key_reg;
    timeout_next    = timeout_reg;
    if (ce) begin
      case (state_reg)
        ST_IDLE: begin
          if (xfer && sel_valid_bit) begin
            if (sel_last) begin
              rr_ptr_next = next_src(xfer_idx);
            end else begin
              state_next      = ST_LOCK;
              lock_owner_next = xfer_idx;
              key_next        = sel_key;
              timeout_next    = '0;
            end
          end
        end
        ST_LOCK: begin
          if (xfer) begin
            timeout_next = '0;
            if (sel_valid_bit && (sel_last || (sel_key != key_reg))) begin
              state_next  = ST_IDLE;
              rr_ptr_next = next_src(lock_owner_reg);
            end
          end else if (!owner_valid) begin
            if (timeout_hit) begin
              state_next   = ST_IDLE;
              rr_ptr_next  = next_src(lock_owner_reg);
              timeout_next = '0;
            end else begin
              timeout_next = timeout_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= '0;
      lock_owner_reg <= '0;
      key_reg        <= '0;
      timeout_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      lock_owner_reg <= lock_owner_next;
      key_reg        <= key_next;
      timeout_reg    <= timeout_next;
    end
  end

  // Output stage: load forwarded flits, drop out_valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
    end else if (ce) begin
      if (xfer && sel_valid_bit) begin
        out_valid_reg <= 1'b1;
        out_flit_reg  <= sel_flit;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_flit    = out_flit_reg;
  assign lock_active = (state_reg == ST_LOCK);
  assign lock_owner  = lock_owner_reg;

endmodule

// File: tb/tb_collector_flit_arbiter.sv
// Directed scoreboard bench for collector_flit_arbiter: per-source flit queues
// feed the DUT, expected output flits are queued when issued, and a monitor
// compares every flit the DUT hands downstream.
module tb_collector_flit_arbiter;

  localparam int RC = 4;
  localparam int FW = 24;

  logic                   clk;
  logic                   rst_n;
  logic                   ce;
  logic [RC-1:0]          req_valid;
  logic [RC-1:0][FW-1:0]  req_flit;
  logic [RC-1:0]          req_ready;
  logic                   out_valid;
  logic [FW-1:0]          out_flit;
  logic                   out_ready;
  logic                   lock_active;
  logic [1:0]             lock_owner;

  int checks;
  int errors;
  int out_count;

  logic [FW-1:0] src_q [RC][$];
  logic [FW-1:0] exp_q [$];
  logic [RC-1:0] hs;

  collector_flit_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .req_valid   (req_valid),
    .req_flit    (req_flit),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_flit    (out_flit),
    .out_ready   (out_ready),
    .lock_active (lock_active),
    .lock_owner  (lock_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flit layout: valid_bit | node_dest | data_byte | packet_id | node_start | byte_index
  function automatic logic [FW-1:0] mk(input logic vb, input logic [2:0] start,
                                       input logic [4:0] pid, input logic [3:0] bidx);
    logic [2:0] dest;
    logic [7:0] data;
    dest = ~start;
    data = {1'b0, start, bidx};
    return {vb, dest, data, pid, start, bidx};
  endfunction

  task automatic send(input int s, input logic [FW-1:0] f, input bit expect_out);
    src_q[s].push_back(f);
    if (expect_out) exp_q.push_back(f);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) until source s has n flits left; returns at posedge+2.
  task automatic wait_src_size(input int s, input int n, input string name);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      #2;
      cnt++;
    end while (src_q[s].size() != n && cnt < 200);
    check(name, src_q[s].size(), n);
  endtask

  // Wait (bounded) until every queue is empty and the output register is idle.
  task automatic wait_drain(input string name);
    int cnt;
    int pending;
    cnt = 0;
    do begin
      @(posedge clk);
      #2;
      cnt++;
      pending = exp_q.size() + int'(out_valid);
      for (int i = 0; i < RC; i++) pending += src_q[i].size();
    end while (pending != 0 && cnt < 300);
    check(name, pending, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Source driver: retire flits accepted at the edge, then present queue heads.
  initial begin
    req_valid = '0;
    req_flit  = '0;
    forever begin
      @(negedge clk);
      hs = (rst_n && ce) ? (req_valid & req_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < RC; i++) begin
        if (hs[i]) void'(src_q[i].pop_front());
      end
      for (int i = 0; i < RC; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_flit[i]  = src_q[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_flit[i]  = '0;
        end
      end
    end
  end

  // Output monitor: each flit consumed downstream is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && ce && out_valid && out_ready) begin
      checks++;
      out_count++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got 0x%0h, expected no flit", out_flit);
      end else begin
        logic [FW-1:0] e;
        e = exp_q.pop_front();
        if (out_flit !== e) begin
          errors++;
          $display("FAIL out_flit #%0d: got 0x%0h, expected 0x%0h", out_count, out_flit, e);
        end else begin
          $display("out flit #%0d: 0x%0h as expected", out_count, out_flit);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] fa;
    checks    = 0;
    errors    = 0;
    out_count = 0;
    rst_n     = 1'b0;
    ce        = 1'b1;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_lock_active", lock_active, 0);
    check("rst_lock_owner", lock_owner, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("idle_no_req_ready", req_ready, 4'b0000);

    // Two full packets: source 0 first, then source 2 (pointer moves to 1)
    for (int b = 0; b < 9; b++) send(0, mk(1'b1, 3'd0, 5'd1, 4'(b)), 1'b1);
    for (int b = 0; b < 9; b++) send(2, mk(1'b1, 3'd2, 5'd3, 4'(b)), 1'b1);
    wait_src_size(0, 8, "t1_first_xfer");
    check("t1_lock_active", lock_active, 1);
    check("t1_lock_owner", lock_owner, 0);
    check("t1_only_owner_ready", req_ready, 4'b0001);
    wait_drain("t1_drain");

    // Lock timeout: source 1 stops after byte 3 while source 3 waits
    do_reset();
    for (int b = 0; b < 4; b++) send(1, mk(1'b1, 3'd1, 5'd2, 4'(b)), 1'b1);
    send(3, mk(1'b1, 3'd3, 5'd4, 4'd8), 1'b1);
    wait_src_size(1, 0, "t2_src1_done");
    check("t2_lock_held", lock_active, 1);
    check("t2_owner_only_ready", req_ready, 4'b0010);
    repeat (15) begin
      @(posedge clk);
      #2;
    end
    check("t2_lock_at_15_idle", lock_active, 1);
    @(posedge clk);
    #2;
    check("t2_lock_dropped_16", lock_active, 0);
    check("t2_src3_granted", req_ready, 4'b1000);
    wait_drain("t2_drain");

    // Key change mid-lock: id 5 -> 6 ends the lock, pointer goes to 3
    do_reset();
    send(2, mk(1'b1, 3'd2, 5'd5, 4'd0), 1'b1);
    send(2, mk(1'b1, 3'd2, 5'd5, 4'd1), 1'b1);
    send(2, mk(1'b1, 3'd2, 5'd6, 4'd2), 1'b1);
    wait_src_size(2, 2, "t3_first_xfer");
    check("t3_lock_active", lock_active, 1);
    check("t3_lock_owner", lock_owner, 2);
    wait_src_size(2, 0, "t3_src2_done");
    check("t3_key_change_idle", lock_active, 0);
    send(3, mk(1'b1, 3'd3, 5'd7, 4'd8), 1'b1);
    send(0, mk(1'b1, 3'd0, 5'd8, 4'd8), 1'b1);
    wait_drain("t3_drain");

    // Discarded flit (valid_bit = 0) from the owner mid-packet
    do_reset();
    send(1, mk(1'b1, 3'd1, 5'd7, 4'd0), 1'b1);
    send(1, mk(1'b0, 3'd1, 5'd3, 4'd8), 1'b0);
    send(1, mk(1'b1, 3'd1, 5'd7, 4'd2), 1'b1);
    send(1, mk(1'b1, 3'd1, 5'd7, 4'd8), 1'b1);
    wait_src_size(1, 3, "t4_first_xfer");
    check("t4_ready_for_invalid", req_ready, 4'b0010);
    wait_src_size(1, 2, "t4_invalid_taken");
    check("t4_out_valid_low", out_valid, 0);
    check("t4_lock_kept", lock_active, 1);
    check("t4_owner_kept", lock_owner, 1);
    @(posedge clk);
    #2;
    check("t4_key_unchanged", lock_active, 1);
    check("t4_next_forwarded", out_valid, 1);
    wait_drain("t4_drain");

    // Downstream stall for 3 cycles, then clock enable low for 2 cycles
    do_reset();
    out_ready = 1'b0;
    fa = mk(1'b1, 3'd0, 5'd9, 4'd8);
    send(0, fa, 1'b1);
    send(1, mk(1'b1, 3'd1, 5'd10, 4'd8), 1'b1);
    wait_src_size(0, 0, "t5_first_xfer");
    for (int k = 0; k < 3; k++) begin
      check("t5_stall_ready", req_ready, 4'b0000);
      check("t5_stall_valid", out_valid, 1);
      check("t5_stall_flit", out_flit, fa);
      if (k < 2) begin
        @(posedge clk);
        #2;
      end
    end
    ce = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t5_ce_low_ready", req_ready, 4'b0000);
    repeat (2) begin
      @(posedge clk);
      #2;
      check("t5_ce_low_valid", out_valid, 1);
      check("t5_ce_low_flit", out_flit, fa);
      check("t5_ce_low_src1_waits", src_q[1].size(), 1);
    end
    ce = 1'b1;
    wait_drain("t5_drain");

    // Reset during LOCK with byte 4 held in the output register
    do_reset();
    for (int b = 0; b < 5; b++) send(1, mk(1'b1, 3'd1, 5'd1, 4'(b)), b < 4);
    wait_src_size(1, 0, "t6_src1_done");
    check("t6_held_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_lock_active", lock_active, 0);
    check("t6_rst_out_flit", out_flit, 0);
    send(0, mk(1'b1, 3'd0, 5'd2, 4'd8), 1'b1);
    send(3, mk(1'b1, 3'd3, 5'd3, 4'd8), 1'b1);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("t6_src0_wins", req_ready, 4'b0001);
    wait_drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
